// File: rtl/snes_video_pkg.sv
// Shared constants for the PPU-side video processor.
//   - B-bus addresses of the PPU registers the snoop decodes
//   - default OSD window bounds (dots / lines)
//   - video region encoding used to pick the OSD Y bounds
`timescale 1ns/1ps
package snes_video_pkg;

  localparam logic [7:0] ADDR_INIDISP = 8'h00;
  localparam logic [7:0] ADDR_BGMODE  = 8'h05;
  localparam logic [7:0] ADDR_M7SEL   = 8'h1A;

  localparam int OSD_X1_DEF   = 64;
  localparam int OSD_X2_DEF   = 256;
  localparam int OSD_Y1_N_DEF = 160;
  localparam int OSD_Y2_N_DEF = 208;
  localparam int OSD_Y1_P_DEF = 180;
  localparam int OSD_Y2_P_DEF = 228;

  typedef enum logic {
    REGION_NTSC = 1'b0,
    REGION_PAL  = 1'b1
  } region_e;

endpackage

// File: rtl/snes_ppu_reg_snoop.sv
// Snoops PPU B-bus writes and keeps shadow copies of the fields the video
// processor needs.
// Ports:
//   MCLK, RESETI          clock, synchronous active-high reset
//   PAWR_N                write strobe, active low, already in the MCLK domain
//   PADDRESS, DATA        B-bus address / data
//   brightness            INIDISP[BRIGHT_W-1:0], all ones after reset
//   force_blank           INIDISP[7]
//   md7_over              mode 7 selected and screen-over mode 2, registered
`timescale 1ns/1ps
module snes_ppu_reg_snoop
  import snes_video_pkg::*;
#(
  parameter int BRIGHT_W = 4
) (
  input  logic                MCLK,
  input  logic                RESETI,
  input  logic                PAWR_N,
  input  logic [7:0]          PADDRESS,
  input  logic [7:0]          DATA,
  output logic [BRIGHT_W-1:0] brightness,
  output logic                force_blank,
  output logic                md7_over
);

  logic pawr_q;
  logic wr;
  logic mode7;
  logic screen_over;
  logic mode7_nxt;
  logic screen_over_nxt;
  logic unused_data;

  // Previous strobe sample resets low so a strobe already low when reset
  // releases is not mistaken for a new falling edge.
  assign wr          = ~PAWR_N & pawr_q;
  assign unused_data = ^DATA[5:4];

  always_comb begin
    mode7_nxt       = mode7;
    screen_over_nxt = screen_over;
    if (wr && PADDRESS == ADDR_BGMODE) mode7_nxt = (DATA[2:0] == 3'd7);
    if (wr && PADDRESS == ADDR_M7SEL)  screen_over_nxt = (DATA[7:6] == 2'b10);
  end

  always_ff @(posedge MCLK) begin
    if (RESETI) begin
      pawr_q      <= 1'b0;
      brightness  <= {BRIGHT_W{1'b1}};
      force_blank <= 1'b0;
      mode7       <= 1'b0;
      screen_over <= 1'b0;
      md7_over    <= 1'b0;
    end else begin
      pawr_q <= PAWR_N;
      if (wr && PADDRESS == ADDR_INIDISP) begin
        brightness  <= DATA[BRIGHT_W-1:0];
        force_blank <= DATA[7];
      end
      mode7       <= mode7_nxt;
      screen_over <= screen_over_nxt;
      // Built from the next-state values so it follows the write by one cycle.
      md7_over    <= mode7_nxt & screen_over_nxt;
    end
  end

endmodule

// File: rtl/snes_ppu_video_proc.sv
// PPU-side video processor: master-brightness scaling of NUM_CH colour
// channels, dot-accurate h/v counters and a dimmed OSD window with font glyphs.
// Ports:
//   MCLK, RESETI         clock, synchronous active-high reset
//   PAWR_N/PADDRESS/DATA PPU register writes (snooped)
//   VBLANK, HBLANK       blanking flags, active high (VBLANK also holds counters)
//   CSYNC_N              composite sync in
//   REGION               0 NTSC, 1 PAL; selects OSD Y bounds
//   OSD_EN               OSD overlay enable
//   PIX_IN               raw colour, ch0 in LSBs
//   FONT_ADDR/FONT_DATA  font ROM port; FONT_DATA is consumed in the cycle
//                        FONT_ADDR is presented (one cycle after it is formed)
//   PIX_OUT              processed colour, two cycles after PIX_IN
//   CSYNC_N_O, BLANK_N_O sync and DAC blank aligned with PIX_OUT
//   MD7_OVER             mode 7 with screen-over mode 2
`timescale 1ns/1ps
module snes_ppu_video_proc
  import snes_video_pkg::*;
#(
  parameter int IN_W      = 5,
  parameter int BRIGHT_W  = 4,
  parameter int OUT_W     = 9,
  parameter int NUM_CH    = 3,
  parameter int DOT_DIV   = 4,
  parameter int H_TOTAL   = 341,
  parameter int OSD_X1    = OSD_X1_DEF,
  parameter int OSD_X2    = OSD_X2_DEF,
  parameter int OSD_Y1_N  = OSD_Y1_N_DEF,
  parameter int OSD_Y1_P  = OSD_Y1_P_DEF,
  parameter int OSD_Y2_N  = OSD_Y2_N_DEF,
  parameter int OSD_Y2_P  = OSD_Y2_P_DEF,
  parameter int OSD_DIM   = 2,
  parameter int GLYPH_W   = 8,
  parameter int ROW_W     = 4,
  parameter int FONT_ROWS = 12
) (
  input  logic                    MCLK,
  input  logic                    RESETI,
  input  logic                    PAWR_N,
  input  logic [7:0]              PADDRESS,
  input  logic [7:0]              DATA,
  input  logic                    VBLANK,
  input  logic                    HBLANK,
  input  logic                    CSYNC_N,
  input  logic                    REGION,
  input  logic                    OSD_EN,
  input  logic [NUM_CH*IN_W-1:0]  PIX_IN,
  output logic [10:0]             FONT_ADDR,
  input  logic [GLYPH_W-1:0]      FONT_DATA,
  output logic [NUM_CH*OUT_W-1:0] PIX_OUT,
  output logic                    CSYNC_N_O,
  output logic                    BLANK_N_O,
  output logic                    MD7_OVER
);

  localparam int PROD_W = IN_W + BRIGHT_W;
  localparam int SHIFT  = PROD_W - OUT_W;
  localparam int DOT_W  = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
  localparam int PX_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int COL_W  = 11 - ROW_W;

  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOT_DIV - 1);
  localparam logic [8:0]       H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0]       X1        = 9'(OSD_X1);
  localparam logic [8:0]       X2        = 9'(OSD_X2);
  localparam logic [8:0]       Y1_N      = 9'(OSD_Y1_N);
  localparam logic [8:0]       Y2_N      = 9'(OSD_Y2_N);
  localparam logic [8:0]       Y1_P      = 9'(OSD_Y1_P);
  localparam logic [8:0]       Y2_P      = 9'(OSD_Y2_P);
  localparam logic [ROW_W-1:0] ROWS_LAST = ROW_W'(FONT_ROWS - 1);

  function automatic logic [OUT_W-1:0] scale_ch(input logic [IN_W-1:0]     pix,
                                                input logic                win,
                                                input logic [BRIGHT_W-1:0] br);
    logic [IN_W-1:0]   c;
    logic [PROD_W-1:0] p;
    c = win ? (pix >> OSD_DIM) : pix;
    p = PROD_W'(c) * PROD_W'(br);
    return OUT_W'(p >> SHIFT);
  endfunction

  logic [BRIGHT_W-1:0] brightness;
  logic                force_blank;

  snes_ppu_reg_snoop #(.BRIGHT_W(BRIGHT_W)) u_snoop (
    .MCLK        (MCLK),
    .RESETI      (RESETI),
    .PAWR_N      (PAWR_N),
    .PADDRESS    (PADDRESS),
    .DATA        (DATA),
    .brightness  (brightness),
    .force_blank (force_blank),
    .md7_over    (MD7_OVER)
  );

  logic [DOT_W-1:0] dot_cnt;
  logic [8:0]       h;
  logic [8:0]       v;
  logic [8:0]       v_inc;
  logic [ROW_W-1:0] glyph_row;
  logic             tick;
  region_e          region;
  logic [8:0]       y1;
  logic [8:0]       y2;

  assign tick   = (dot_cnt == DOT_LAST);
  assign v_inc  = v + 9'd1;
  assign region = region_e'(REGION);
  assign y1     = (region == REGION_PAL) ? Y1_P : Y1_N;
  assign y2     = (region == REGION_PAL) ? Y2_P : Y2_N;

  // glyph_row tracks (v - Y1 - 1) mod FONT_ROWS incrementally: it restarts on
  // the first window line and wraps at FONT_ROWS on every later line.
  always_ff @(posedge MCLK) begin
    if (RESETI || VBLANK) begin
      dot_cnt   <= '0;
      h         <= '0;
      v         <= '0;
      glyph_row <= '0;
    end else begin
      dot_cnt <= tick ? '0 : dot_cnt + 1'b1;
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= v_inc;
          if (v_inc == y1 + 9'd1)        glyph_row <= '0;
          else if (glyph_row == ROWS_LAST) glyph_row <= '0;
          else                           glyph_row <= glyph_row + 1'b1;
        end else begin
          h <= h + 9'd1;
        end
      end
    end
  end

  logic             in_win;
  logic [8:0]       col;
  logic [COL_W-1:0] char_col;

  assign in_win   = OSD_EN && (h > X1) && (h <= X2) && (v > y1) && (v <= y2);
  assign col      = h - X1 - 9'd1;
  assign char_col = COL_W'(col >> PX_W);

  // ---- S0: register font address, window state, pixel and sync ----
  logic [PX_W-1:0]        px_p0;
  logic                   win_p0;
  logic                   vld_p0;
  logic                   csync_p0;
  logic [NUM_CH*IN_W-1:0] pix_p0;
  logic [BRIGHT_W-1:0]    bright_p0;

  always_ff @(posedge MCLK) begin
    if (RESETI) begin
      FONT_ADDR <= '0;
      px_p0     <= '0;
      win_p0    <= 1'b0;
      vld_p0    <= 1'b0;
      csync_p0  <= 1'b1;
      pix_p0    <= '0;
      bright_p0 <= '0;
    end else begin
      FONT_ADDR <= {char_col, glyph_row};
      px_p0     <= col[PX_W-1:0];
      win_p0    <= in_win;
      vld_p0    <= ~(VBLANK | HBLANK | force_blank);
      csync_p0  <= CSYNC_N;
      pix_p0    <= PIX_IN;
      bright_p0 <= brightness;
    end
  end

  // ---- S1: font data valid, per-channel product and overrides ----
  logic [GLYPH_W-1:0]      font_rev;
  logic                    font_bit;
  logic [NUM_CH*OUT_W-1:0] pix_s1;

  // Bit-reverse so px indexes the glyph from its leftmost (MSB) dot.
  for (genvar i = 0; i < GLYPH_W; i++) begin : g_rev
    assign font_rev[i] = FONT_DATA[GLYPH_W-1-i];
  end

  assign font_bit = font_rev[px_p0];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign pix_s1[ch*OUT_W +: OUT_W] =
      !vld_p0               ? {OUT_W{1'b0}} :
      (win_p0 && font_bit)  ? {OUT_W{1'b1}} :
      scale_ch(pix_p0[ch*IN_W +: IN_W], win_p0, bright_p0);
  end

  // ---- S2: output registers ----
  always_ff @(posedge MCLK) begin
    if (RESETI) begin
      PIX_OUT   <= '0;
      BLANK_N_O <= 1'b0;
      CSYNC_N_O <= 1'b1;
    end else begin
      PIX_OUT   <= pix_s1;
      BLANK_N_O <= vld_p0;
      CSYNC_N_O <= csync_p0;
    end
  end

endmodule
